// File: rtl/vadd_sat_cmp.sv
// vadd_sat_cmp: pipelined elementwise vector add/sub/min/max, saturating
// add/sub and mask-producing compares over SEW-sized lanes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = pipeline advance)
//   in_vec0, in_vec1  operands a (vs2) and b (vs1/scalar)
//   in_sew            element width code: 0=8b, 1=16b, 2=32b, 3=64b
//   in_op             operation code (0..15)
//   in_addr           destination tag carried with the beat
//   out_valid/out_ready output handshake
//   out_vec, out_sat, out_addr  result data, saturation flag, tag
//
// Stage 1 registers the operands, the lane core sits between stage 1 and
// stage 2, and stages 3..LATENCY only delay. One advance enable moves every
// stage at once, so a stalled output freezes the whole pipe.
module vadd_sat_cmp #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned SAT_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [SEW_WIDTH-1:0]  in_sew,
  input  logic [3:0]            in_op,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic                  out_sat,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam int unsigned OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_MINU  = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_MIN   = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_MAXU  = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_MAX   = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_SADDU = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_SADD  = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_SSUBU = 4'd8;
  localparam logic [OP_WIDTH-1:0] OP_SSUB  = 4'd9;
  localparam logic [OP_WIDTH-1:0] OP_MSEQ  = 4'd10;
  localparam logic [OP_WIDTH-1:0] OP_MSNE  = 4'd11;
  localparam logic [OP_WIDTH-1:0] OP_MSLTU = 4'd12;
  localparam logic [OP_WIDTH-1:0] OP_MSLT  = 4'd13;
  localparam logic [OP_WIDTH-1:0] OP_MSLEU = 4'd14;
  localparam logic [OP_WIDTH-1:0] OP_MSLE  = 4'd15;

  // Advance enable shared by every stage
  logic adv_c;

  // Stage 1: registered operands
  logic                  s1_v_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [SEW_WIDTH-1:0]  s1_sew_q, s1_sew_d;
  logic [OP_WIDTH-1:0]   s1_op_q, s1_op_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;

  // Stages 2..LATENCY: results
  logic                  pv_q    [2:LATENCY];
  logic [DATA_WIDTH-1:0] pvec_q  [2:LATENCY];
  logic                  psat_q  [2:LATENCY];
  logic [ADDR_WIDTH-1:0] paddr_q [2:LATENCY];

  logic [DATA_WIDTH-1:0] s2_vec_d;
  logic                  s2_sat_d;
  logic [ADDR_WIDTH-1:0] s2_addr_d;

  // Core outputs
  logic [OP_WIDTH-1:0]   op_eff_c;
  logic [DATA_WIDTH-1:0] core_vec_c;
  logic                  core_sat_c;

  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  // Without saturation support the saturating ops fold onto plain add/sub
  if (SAT_ENABLE != 0) begin : g_sat
    assign op_eff_c = s1_op_q;
  end else begin : g_nosat
    always_comb begin
      op_eff_c = s1_op_q;
      if (s1_op_q == OP_SADDU || s1_op_q == OP_SADD) begin
        op_eff_c = OP_ADD;
      end else if (s1_op_q == OP_SSUBU || s1_op_q == OP_SSUB) begin
        op_eff_c = OP_SUB;
      end
    end
  end

  // One lane array per element width; the sew of the beat picks one
  for (genvar gs = 0; gs < 4; gs++) begin : g_sew
    localparam int unsigned EW = 8 << gs;
    localparam int unsigned NE = DATA_WIDTH / EW;

    logic [DATA_WIDTH-1:0] vec_c;
    logic                  sat_c;
    logic [EW-1:0]         ea, eb, er;
    logic [EW:0]           sum, dif;
    logic                  ovf_add, ovf_sub, ltu, lts, eq, cmp, clamp, is_mask;

    always_comb begin
      vec_c   = '0;
      sat_c   = 1'b0;
      ea      = '0;
      eb      = '0;
      er      = '0;
      sum     = '0;
      dif     = '0;
      ovf_add = 1'b0;
      ovf_sub = 1'b0;
      ltu     = 1'b0;
      lts     = 1'b0;
      eq      = 1'b0;
      cmp     = 1'b0;
      clamp   = 1'b0;
      is_mask = (op_eff_c >= OP_MSEQ);
      for (int i = 0; i < int'(NE); i++) begin
        ea  = s1_a_q[i*EW +: EW];
        eb  = s1_b_q[i*EW +: EW];
        sum = {1'b0, ea} + {1'b0, eb};
        dif = {1'b0, ea} - {1'b0, eb};
        // Signed overflow: operand signs vs result sign
        ovf_add = (ea[EW-1] == eb[EW-1]) && (sum[EW-1] != ea[EW-1]);
        ovf_sub = (ea[EW-1] != eb[EW-1]) && (dif[EW-1] != ea[EW-1]);
        ltu     = dif[EW];
        // Same signs: unsigned order holds; differing signs: negative a is less
        lts     = (ea[EW-1] != eb[EW-1]) ? ea[EW-1] : ltu;
        eq      = (ea == eb);
        er      = sum[EW-1:0];
        cmp     = 1'b0;
        clamp   = 1'b0;
        case (op_eff_c)
          OP_ADD:   er = sum[EW-1:0];
          OP_SUB:   er = dif[EW-1:0];
          OP_MINU:  er = (ltu || eq) ? ea : eb;
          OP_MIN:   er = (lts || eq) ? ea : eb;
          OP_MAXU:  er = ltu ? eb : ea;
          OP_MAX:   er = lts ? eb : ea;
          OP_SADDU: begin
            er    = sum[EW] ? {EW{1'b1}} : sum[EW-1:0];
            clamp = sum[EW];
          end
          OP_SADD: begin
            er    = sum[EW-1:0];
            clamp = ovf_add;
            if (ovf_add) begin
              er = ea[EW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
            end
          end
          OP_SSUBU: begin
            er    = dif[EW] ? '0 : dif[EW-1:0];
            clamp = dif[EW];
          end
          OP_SSUB: begin
            er    = dif[EW-1:0];
            clamp = ovf_sub;
            if (ovf_sub) begin
              er = ea[EW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
            end
          end
          OP_MSEQ:  cmp = eq;
          OP_MSNE:  cmp = !eq;
          OP_MSLTU: cmp = ltu;
          OP_MSLT:  cmp = lts;
          OP_MSLEU: cmp = ltu || eq;
          OP_MSLE:  cmp = lts || eq;
          default:  er = sum[EW-1:0];
        endcase
        if (is_mask) begin
          vec_c[i] = cmp;
        end else begin
          vec_c[i*EW +: EW] = er;
        end
        sat_c = sat_c | clamp;
      end
    end
  end

  // Select the lane array matching the beat's element width
  always_comb begin
    core_vec_c = g_sew[3].vec_c;
    core_sat_c = g_sew[3].sat_c;
    if (s1_sew_q == SEW_WIDTH'(0)) begin
      core_vec_c = g_sew[0].vec_c;
      core_sat_c = g_sew[0].sat_c;
    end else if (s1_sew_q == SEW_WIDTH'(1)) begin
      core_vec_c = g_sew[1].vec_c;
      core_sat_c = g_sew[1].sat_c;
    end else if (s1_sew_q == SEW_WIDTH'(2)) begin
      core_vec_c = g_sew[2].vec_c;
      core_sat_c = g_sew[2].sat_c;
    end
  end

  // Next-state for stages 1 and 2; empty beats load zeros
  always_comb begin
    s1_a_d    = '0;
    s1_b_d    = '0;
    s1_sew_d  = '0;
    s1_op_d   = '0;
    s1_addr_d = '0;
    s2_vec_d  = '0;
    s2_sat_d  = 1'b0;
    s2_addr_d = '0;
    if (in_valid) begin
      s1_a_d    = in_vec0;
      s1_b_d    = in_vec1;
      s1_sew_d  = in_sew;
      s1_op_d   = in_op;
      s1_addr_d = in_addr;
    end
    if (s1_v_q) begin
      s2_vec_d  = core_vec_c;
      s2_sat_d  = core_sat_c;
      s2_addr_d = s1_addr_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_sew_q  <= '0;
      s1_op_q   <= '0;
      s1_addr_q <= '0;
      for (int k = 2; k <= int'(LATENCY); k++) begin
        pv_q[k]    <= 1'b0;
        pvec_q[k]  <= '0;
        psat_q[k]  <= 1'b0;
        paddr_q[k] <= '0;
      end
    end else if (adv_c) begin
      s1_v_q     <= in_valid;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sew_q   <= s1_sew_d;
      s1_op_q    <= s1_op_d;
      s1_addr_q  <= s1_addr_d;
      pv_q[2]    <= s1_v_q;
      pvec_q[2]  <= s2_vec_d;
      psat_q[2]  <= s2_sat_d;
      paddr_q[2] <= s2_addr_d;
      for (int k = 3; k <= int'(LATENCY); k++) begin
        pv_q[k]    <= pv_q[k-1];
        pvec_q[k]  <= pv_q[k-1] ? pvec_q[k-1]  : '0;
        psat_q[k]  <= pv_q[k-1] ? psat_q[k-1]  : 1'b0;
        paddr_q[k] <= pv_q[k-1] ? paddr_q[k-1] : '0;
      end
    end
  end

  assign out_valid = pv_q[LATENCY];
  assign out_vec   = pvec_q[LATENCY];
  assign out_sat   = psat_q[LATENCY];
  assign out_addr  = paddr_q[LATENCY];

endmodule
